// File: rtl/pulse_sched_if.sv
// pulse_sched_if: requester/pulser-side signal bundle for the pulser scheduler.
// master drives requests and the pulser error flag; slave is the scheduler.
interface pulse_sched_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic [7:0] burst_len;
    logic [7:0] pulse_count;
    logic abort;
    logic pulser_trig;
    logic pulser_error;
    logic busy;
    modport master (
        output req, burst_len, pulser_error,
        input grant, done, abort, pulser_trig, pulse_count, busy
    );
    modport slave (
        input req, burst_len, pulser_error,
        output grant, done, abort, pulser_trig, pulse_count, busy
    );
endinterface

// File: rtl/pulse_sched.sv
// pulse_sched: round-robin owner of the HV pulser issuing evenly spaced trigger bursts.
// Define PULSE_SCHED_PRIORITY_EN to give requester 0 fixed priority over the rest.
module pulse_sched #(
    parameter int NUM_REQ = 3,
    parameter logic [11:0] PERIOD_CLKS = 12'hA00,
    parameter logic [11:0] TRIG_WIDTH = 12'h4
) (
    input logic clk,
    input logic reset,
    pulse_sched_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, TRIG, SPACE, DONE} state_t;
    state_t state_q;
    logic [NUM_REQ-1:0] grant_q, done_q, rq, rot, win_oh;
    logic [IW-1:0] rr_q, owner_q, win_idx, rr_d;
    logic [11:0] cnt_q;
    logic [7:0] pcnt_q, len_q;
    logic abort_q, trig_q, busy_q, win;
    always_comb begin
`ifdef PULSE_SCHED_PRIORITY_EN
        rq = bus.req & ~NUM_REQ'(1);
`else
        rq = bus.req;
`endif
        rot = NUM_REQ'({rq, rq} >> rr_q);
        win = 1'b0;
        win_idx = '0;
        // descending scan so the requester nearest the pointer overrides
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win = 1'b1;
                win_idx = IW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
`ifdef PULSE_SCHED_PRIORITY_EN
        if (bus.req[0]) begin
            win = 1'b1;
            win_idx = '0;
        end
        rr_d = (owner_q == IW'(NUM_REQ - 1)) ? IW'(1) : owner_q + 1'b1;
`else
        rr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
        win_oh = NUM_REQ'(1) << win_idx;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q <= '0;
            abort_q <= 1'b0;
            trig_q <= 1'b0;
            busy_q <= 1'b0;
            pcnt_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            rr_q <= '0;
            owner_q <= '0;
        end else begin
            done_q <= '0;
            abort_q <= 1'b0;
            if (state_q == TRIG && cnt_q == '0) pcnt_q <= pcnt_q + 8'd1;
            case (state_q)
                IDLE: if (win && !bus.pulser_error) begin
                    grant_q <= win_oh;
                    owner_q <= win_idx;
                    len_q <= bus.burst_len;
                    pcnt_q <= '0;
                    cnt_q <= '0;
                    busy_q <= 1'b1;
                    trig_q <= bus.burst_len != 8'd0;
                    done_q <= (bus.burst_len == 8'd0) ? win_oh : '0;
                    state_q <= (bus.burst_len == 8'd0) ? DONE : TRIG;
                end
                TRIG, SPACE: if (bus.pulser_error) begin
                    trig_q <= 1'b0;
                    abort_q <= 1'b1;
                    done_q <= grant_q;
                    state_q <= DONE;
                end else if (state_q == TRIG) begin
                    cnt_q <= cnt_q + 12'd1;
                    trig_q <= (cnt_q + 12'd1) < TRIG_WIDTH;
                    if (cnt_q == TRIG_WIDTH - 12'd1) state_q <= SPACE;
                end else if (cnt_q == PERIOD_CLKS - 12'd1) begin
                    if (pcnt_q == len_q) begin
                        done_q <= grant_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= '0;
                        trig_q <= 1'b1;
                        state_q <= TRIG;
                    end
                end else begin
                    cnt_q <= cnt_q + 12'd1;
                end
                DONE: begin
                    grant_q <= '0;
                    busy_q <= 1'b0;
                    rr_q <= rr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.grant = grant_q;
    assign bus.done = done_q;
    assign bus.abort = abort_q;
    assign bus.pulser_trig = trig_q;
    assign bus.pulse_count = pcnt_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: scoreboard bench; stimulus queues expected trigger rises and
// done strobes, negedge monitors pop and compare them as the DUT produces them.
module tb_pulse_sched;
    localparam int P = 2560;
    localparam int TW = 4;
    typedef struct {
        int cyc;
        logic [2:0] dn;
        logic ab;
        logic [7:0] pc;
    } done_t;
    typedef struct {
        int cyc;
        logic [2:0] gr;
    } trig_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int width = 0;
    logic trig_prev = 1'b0;
    done_t dq[$];
    trig_t tq[$];
    pulse_sched_if #(.NUM_REQ(3)) bus();
    pulse_sched #(.NUM_REQ(3), .PERIOD_CLKS(12'hA00), .TRIG_WIDTH(12'h4)) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        done_t d;
        trig_t t;
        if (rst) begin
            width = 0;
        end else begin
            if (bus.done != 3'b000) begin
                if (dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got done=%b expected none (cyc %0d)", bus.done, cyc);
                end else begin
                    d = dq.pop_front();
                    chk("done_cyc", cyc, d.cyc);
                    chk("done_vec", int'(bus.done), int'(d.dn));
                    chk("abort", int'(bus.abort), int'(d.ab));
                    chk("pulse_count", int'(bus.pulse_count), int'(d.pc));
                end
            end
            if (bus.pulser_trig && !trig_prev) begin
                if (tq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL trig_unexpected: got rise expected none (cyc %0d)", cyc);
                end else begin
                    t = tq.pop_front();
                    chk("trig_cyc", cyc, t.cyc);
                    chk("trig_grant", int'(bus.grant), int'(t.gr));
                end
            end
            if (bus.pulser_trig) width++;
            else if (trig_prev) begin
                chk("trig_width", width, TW);
                width = 0;
            end
        end
        trig_prev = bus.pulser_trig;
    end
    task automatic burst(input logic [2:0] r, input logic [7:0] len, input logic [2:0] g);
        int e0 = cyc + 1;
        bus.req = r;
        bus.burst_len = len;
        for (int i = 0; i < int'(len); i++) tq.push_back('{e0 + i * P, g});
        dq.push_back('{(len == 8'd0) ? e0 : e0 + int'(len) * P, g, 1'b0, len});
        @(negedge clk);
        chk("grant", int'(bus.grant), int'(g));
        chk("busy", int'(bus.busy), 1);
        bus.req = 3'b000;
        bus.burst_len = 8'd77;
        repeat (int'(len) * P + 4) @(negedge clk);
    endtask
    initial begin
        int e0;
        int ce;
        bus.req = 3'b000;
        bus.burst_len = 8'd0;
        bus.pulser_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_trig", int'(bus.pulser_trig), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_pcnt", int'(bus.pulse_count), 0);
        burst(3'b001, 8'd3, 3'b001);
        burst(3'b010, 8'd0, 3'b010);
        // reset while the first trigger pulse is high
        e0 = cyc + 1;
        bus.req = 3'b100;
        bus.burst_len = 8'd2;
        tq.push_back('{e0, 3'b100});
        repeat (2) @(negedge clk);
        bus.req = 3'b000;
        chk("pre_rst_trig", int'(bus.pulser_trig), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_trig", int'(bus.pulser_trig), 0);
        chk("mid_rst_grant", int'(bus.grant), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // all requesting: rotation restarts at requester 0
        e0 = cyc + 1;
        bus.req = 3'b111;
        bus.burst_len = 8'd1;
        for (int i = 0; i < 4; i++) begin
            tq.push_back('{e0 + i * (P + 2), 3'b001 << (i % 3)});
            dq.push_back('{e0 + i * (P + 2) + P, 3'b001 << (i % 3), 1'b0, 8'd1});
        end
        repeat (3 * (P + 2) + P + 1) @(negedge clk);
        bus.req = 3'b000;
        repeat (4) @(negedge clk);
        // pulser error during the second spacing interval
        e0 = cyc + 1;
        bus.req = 3'b010;
        bus.burst_len = 8'd5;
        tq.push_back('{e0, 3'b010});
        tq.push_back('{e0 + P, 3'b010});
        repeat (P + 101) @(negedge clk);
        ce = cyc;
        dq.push_back('{ce + 1, 3'b010, 1'b1, 8'd2});
        bus.pulser_error = 1'b1;
        repeat (40) @(negedge clk);
        chk("err_grant", int'(bus.grant), 0);
        chk("err_busy", int'(bus.busy), 0);
        chk("err_pcnt", int'(bus.pulse_count), 2);
        ce = cyc;
        bus.pulser_error = 1'b0;
        bus.burst_len = 8'd0;
        dq.push_back('{ce + 1, 3'b010, 1'b0, 8'd0});
        @(negedge clk);
        bus.req = 3'b000;
        repeat (5) @(negedge clk);
        chk("trig_left", tq.size(), 0);
        chk("done_left", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
